// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - key debounce, PLL-lock gating and ordered multi-domain reset release
module reset_sequencer #(
    parameter int NUM_DOMAINS     = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STAGE_CYCLES    = 1024,
    parameter int READY_TIMEOUT   = 5000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_n,
    input  logic                   pll_lock,
    input  logic [NUM_DOMAINS-1:0] stage_ready,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   seq_done,
    output logic                   key_state,
    output logic                   fault
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int IW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CMAX = (STAGE_CYCLES > READY_TIMEOUT) ? STAGE_CYCLES : READY_TIMEOUT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(READY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_DELAY,
        S_WAIT_READY,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_key_sync;
    logic [1:0]             r_lock_sync;
    logic [NUM_DOMAINS-1:0] r_ready_m;
    logic [NUM_DOMAINS-1:0] r_ready_s;
    logic [DW-1:0]          r_db_cnt;
    logic                   r_key_state;
    logic [IW-1:0]          r_idx;
    logic [CW-1:0]          r_cnt;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic                   r_fault;

    logic                   w_key_pressed;
    logic                   w_lock_s;
    logic                   w_key_rise;
    logic [NUM_DOMAINS-1:0] w_sel;
    logic                   w_ready_sel;
    logic                   w_release;
    logic                   w_advance;
    logic                   w_set_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_sync  <= 2'b11;
            r_lock_sync <= 2'b00;
            r_ready_m   <= '0;
            r_ready_s   <= '0;
        end else begin
            r_key_sync  <= {r_key_sync[0], key_n};
            r_lock_sync <= {r_lock_sync[0], pll_lock};
            r_ready_m   <= stage_ready;
            r_ready_s   <= r_ready_m;
        end
    end

    assign w_key_pressed = ~r_key_sync[1];
    assign w_lock_s      = r_lock_sync[1];
    assign w_key_rise    = w_key_pressed && !r_key_state && (r_db_cnt == DB_LAST);
    assign w_sel         = NUM_DOMAINS'(1) << r_idx;
    assign w_ready_sel   = |(r_ready_s & w_sel);

    // Any stable deviation from the accepted level must persist DEBOUNCE_CYCLES edges to flip it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt    <= '0;
            r_key_state <= 1'b0;
        end else if (w_key_pressed == r_key_state) begin
            r_db_cnt    <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt    <= '0;
            r_key_state <= ~r_key_state;
        end else begin
            r_db_cnt    <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key abort outranks lock loss so a user reset never leaves a fault behind
    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        w_advance   = 1'b0;
        w_set_fault = 1'b0;
        if (r_state != S_HOLD && r_key_state) begin
            w_state_nxt = S_HOLD;
        end else if (!w_lock_s && (r_state == S_DELAY || r_state == S_WAIT_READY
                                   || r_state == S_RUN)) begin
            w_state_nxt = S_HOLD;
            w_set_fault = 1'b1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (!r_key_state) w_state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) w_state_nxt = S_DELAY;
                end
                S_DELAY: begin
                    if (r_cnt == STAGE_LAST) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    if (w_ready_sel) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_advance   = 1'b1;
                            w_state_nxt = S_DELAY;
                        end
                    end else if (r_cnt == TMO_LAST) begin
                        w_set_fault = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_key_rise) begin
                r_fault <= 1'b0;
            end else if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (w_state_nxt == S_HOLD) begin
                r_idx   <= '0;
                r_cnt   <= '0;
                r_rst_n <= '0;
            end else if (w_release) begin
                r_rst_n <= r_rst_n | w_sel;
                r_cnt   <= '0;
            end else if (w_advance) begin
                r_idx   <= r_idx + 1'b1;
                r_cnt   <= '0;
            end else if (r_state == S_DELAY || r_state == S_WAIT_READY) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    always_comb begin
        seq_done  = (r_state == S_RUN);
        rst_n_out = r_rst_n;
        key_state = r_key_state;
        fault     = r_fault;
    end
endmodule
